pdm_pcm_mic_interface: RTL and testbench

Front-end stage between the external PDM microphone pins and pdm_pcm_decimator. Generates the microphone bit clock from the system clock and samples the mic data pin on the selected edge through a synchroniser. It discards the mic start-up bits, buffers captured bits in a small FIFO, and presents them on a valid/ready bit stream that feeds the decimator's PDM input.

---
 rtl/pdm_pcm_converter_pkg.sv | 20 ++
 rtl/pdm_pcm_mic_interface_if.sv | 10 +
 rtl/pdm_pcm_bit_fifo.sv | 49 ++++
 rtl/pdm_pcm_mic_interface.sv | 132 +++++++++++++
 tb/tb_pdm_pcm_mic_interface.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_pcm_converter_pkg.sv
// Shared types and helpers for the PDM microphone front-end.
package pdm_pcm_converter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        STOP   = 2'd3
    } mic_state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    // The half-period must leave room for the synchroniser plus one cycle of mic output delay.
    function automatic int unsigned min_half_period(input int unsigned clk_div,
                                                    input int unsigned sync_stages);
        return (clk_div > sync_stages) ? clk_div : sync_stages + 1;
    endfunction

endpackage

// File: rtl/pdm_pcm_mic_interface_if.sv
// Captured PDM bit stream towards the decimator.
// A bit transfers on every clock where pdm_valid && pdm_ready; pdm_data is stable while valid waits.
interface pdm_pcm_mic_interface_if;
    logic pdm_data;
    logic pdm_valid;
    logic pdm_ready;

    modport master (output pdm_data, output pdm_valid, input pdm_ready);
    modport slave  (input pdm_data, input pdm_valid, output pdm_ready);
endinterface

// File: rtl/pdm_pcm_bit_fifo.sv
// 1-bit synchronous FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module pdm_pcm_bit_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 1'b0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pdm_pcm_mic_interface.sv
// PDM mic front-end: bit-clock divider, data synchroniser, warm-up/run/stop FSM and bit FIFO.
module pdm_pcm_mic_interface
    import pdm_pcm_converter_pkg::*;
#(
    parameter int PDM_PCM_CONVERTER_CLK_DIV_WIDTH  = 8,
    parameter int PDM_PCM_CONVERTER_SYNC_STAGES    = 2,
    parameter int PDM_PCM_CONVERTER_BIT_FIFO_DEPTH = 8,
    parameter int PDM_PCM_CONVERTER_WARMUP_BITS    = 16
) (
    input  logic                                       clock_i,
    input  logic                                       reset_i,
    input  logic                                       enable_i,
    input  logic [PDM_PCM_CONVERTER_CLK_DIV_WIDTH-1:0] clk_div_i,
    input  logic                                       edge_sel_i,
    output logic                                       pdm_clk_o,
    input  logic                                       pdm_mic_data_i,
    pdm_pcm_mic_interface_if.master                    pdm,
    output logic                                       busy_o,
    output logic                                       overflow_o,
    output mic_state_t                                 state_dbg
);
    localparam int DW    = PDM_PCM_CONVERTER_CLK_DIV_WIDTH;
    localparam int SS    = PDM_PCM_CONVERTER_SYNC_STAGES;
    localparam int DEPTH = PDM_PCM_CONVERTER_BIT_FIFO_DEPTH;
    localparam int WB    = PDM_PCM_CONVERTER_WARMUP_BITS;
    localparam int WW    = (WB > 0) ? $clog2(WB + 1) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'((WB > 0) ? WB - 1 : 0);

    mic_state_t    state;
    mic_state_t    next_state;
    logic [DW-1:0] half_eff;
    logic [DW-1:0] half_q;
    logic [DW-1:0] cnt;
    logic          clk_q;
    logic          edge_q;
    logic          had_edge;
    logic [WW-1:0] warm_cnt;
    logic [SS-1:0] sync_q;
    logic          wrap;
    logic          capture;
    logic          push;
    logic          warm_step;
    logic          fifo_full;
    logic          fifo_empty;

    assign half_eff = DW'(min_half_period(32'(clk_div_i), SS));
    assign wrap     = (state != IDLE) && (cnt == half_q - 1'b1);
    // The low phase before the first rising edge does not start with a falling edge, so it never captures.
    assign capture  = wrap && ((edge_q == EDGE_RISING) ? clk_q : (!clk_q && had_edge));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable_i) next_state = (WB == 0) ? RUN : WARMUP;
            WARMUP:  if (!enable_i) next_state = STOP;
                     else if (capture && (warm_cnt == WARM_LAST)) next_state = RUN;
            RUN:     if (!enable_i) next_state = STOP;
            STOP:    if (wrap) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        warm_step = 1'b0;
        case (state)
            WARMUP:  warm_step = capture;
            RUN:     push      = capture;
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt      <= '0;
            clk_q    <= 1'b0;
            half_q   <= '0;
            edge_q   <= EDGE_RISING;
            had_edge <= 1'b0;
            warm_cnt <= '0;
        end else if (state == IDLE) begin
            cnt      <= '0;
            clk_q    <= 1'b0;
            had_edge <= 1'b0;
            warm_cnt <= '0;
            if (enable_i) begin
                half_q <= half_eff;
                edge_q <= edge_sel_i;
            end
        end else begin
            if (wrap) begin
                cnt      <= '0;
                // STOP only ever ends on a low clock: a high phase falls, a low phase just stays low.
                clk_q    <= (state == STOP) ? 1'b0 : ~clk_q;
                had_edge <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (warm_step) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[SS-2:0], pdm_mic_data_i};
    end

    pdm_pcm_bit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clock_i),
        .rst      (reset_i),
        .push     (push),
        .push_data(sync_q[SS-1]),
        .pop      (pdm.pdm_ready),
        .head     (pdm.pdm_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pdm.pdm_valid = !fifo_empty;
    assign pdm_clk_o     = clk_q;
    assign overflow_o    = push && fifo_full && !pdm.pdm_ready;
    assign busy_o        = (state != IDLE) || !fifo_empty;
    assign state_dbg     = state;

endmodule

// File: tb/tb_pdm_pcm_mic_interface.sv
// Directed bench for pdm_pcm_mic_interface with a mic model and an expected-bit queue.
module tb_pdm_pcm_mic_interface;
    import pdm_pcm_converter_pkg::*;

    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int DEPTH = 8;
    localparam int WB    = 16;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic [DW-1:0] clk_div_i;
    logic          edge_sel_i;
    logic          pdm_clk_o;
    logic          pdm_mic_data_i;
    logic          busy_o;
    logic          overflow_o;
    mic_state_t    state_dbg;

    pdm_pcm_mic_interface_if pdm ();

    pdm_pcm_mic_interface #(
        .PDM_PCM_CONVERTER_CLK_DIV_WIDTH (DW),
        .PDM_PCM_CONVERTER_SYNC_STAGES   (SS),
        .PDM_PCM_CONVERTER_BIT_FIFO_DEPTH(DEPTH),
        .PDM_PCM_CONVERTER_WARMUP_BITS   (WB)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .clk_div_i     (clk_div_i),
        .edge_sel_i    (edge_sel_i),
        .pdm_clk_o     (pdm_clk_o),
        .pdm_mic_data_i(pdm_mic_data_i),
        .pdm           (pdm),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o),
        .state_dbg     (state_dbg)
    );

    always #5 clock_i = ~clock_i;

    logic [0:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0, last_rise = 0, period = 0, high_len = 0, rises = 0, falls = 0;
    int sel_cnt = 0, captures = 0, exp_ovf = 0, ovf_cnt = 0, h = 4;
    bit prev_clk = 1'b0, en_model = 1'b0, pend_valid = 1'b0, pend_val = 1'b0;
    bit mic_random = 1'b0, mon_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Mic model: a new bit per half-period; bits of selected phases past warm-up are expected at phase end.
    task automatic tick();
        @(posedge clock_i);
        #2;
        cyc++;
        if (pdm_clk_o !== prev_clk) begin
            if (pend_valid) begin
                captures++;
                if (exp_q.size() < DEPTH) exp_q.push_back(pend_val);
                else exp_ovf++;
            end
            pend_valid = 1'b0;
            prev_clk   = pdm_clk_o;
            if (prev_clk) begin
                rises++;
                period    = cyc - last_rise;
                last_rise = cyc;
            end else begin
                falls++;
                high_len = cyc - last_rise;
            end
            pdm_mic_data_i = mic_random ? 1'($urandom_range(0, 1)) : 1'b1;
            if (en_model && (prev_clk == (edge_sel_i == EDGE_RISING))) begin
                sel_cnt++;
                if (sel_cnt > WB) begin
                    pend_valid = 1'b1;
                    pend_val   = pdm_mic_data_i;
                end
            end
        end
    endtask

    task automatic start_run(input int div, input logic es, input bit rnd);
        clk_div_i  = DW'(div);
        edge_sel_i = es;
        mic_random = rnd;
        h          = (div > SS) ? div : SS + 1;
        sel_cnt    = 0;
        rises      = 0;
        falls      = 0;
        pend_valid = 1'b0;
        prev_clk   = 1'b0;
        en_model   = 1'b1;
        enable_i   = 1'b1;
    endtask

    task automatic wait_captures(input int n, input int budget);
        int target;
        target = captures + n;
        for (int i = 0; i < budget && captures < target; i++) tick();
        check("wait_captures", captures >= target, 1);
    endtask

    task automatic first_rise(input string tag);
        int k;
        k = 0;
        while (pdm_clk_o !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check(tag, k, h + 1);
    endtask

    task automatic stop_run();
        int e0;
        e0 = rises + falls;
        for (int i = 0; i < 60 && rises + falls == e0; i++) tick();
        enable_i   = 1'b0;
        en_model   = 1'b0;
        pend_valid = 1'b0;
        for (int i = 0; i < 60 && state_dbg != IDLE; i++) tick();
        check("stop_idle", state_dbg, IDLE);
    endtask

    always @(negedge clock_i) begin
        if (overflow_o === 1'b1) ovf_cnt++;
        if (mon_on) begin
            check("valid", pdm.pdm_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("data", pdm.pdm_data, exp_q[0]);
            else check("data_empty", pdm.pdm_data, 0);
            if (pdm.pdm_valid === 1'b1 && pdm.pdm_ready === 1'b1 && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    initial begin
        int k, r0, c0, ovf0, highs;
        reset_i        = 1'b1;
        enable_i       = 1'b0;
        clk_div_i      = 8'd4;
        edge_sel_i     = EDGE_RISING;
        pdm_mic_data_i = 1'b1;
        pdm.pdm_ready  = 1'b1;
        repeat (3) @(posedge clock_i);
        #2;
        check("rst_pdm_clk", pdm_clk_o, 0);
        check("rst_valid", pdm.pdm_valid, 0);
        check("rst_data", pdm.pdm_data, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_state", state_dbg, IDLE);
        reset_i = 1'b0;
        tick();
        mon_on = 1'b1;

        // Mic tied high, divide by 4, rising-edge channel.
        start_run(4, EDGE_RISING, 1'b0);
        first_rise("first_rise_div4");
        k = 0;
        while (pdm.pdm_valid !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check("first_valid_after_fall", falls, WB + 1);
        check("period_div4", period, 2 * h);
        check("high_len_div4", high_len, h);
        mic_random = 1'b1;
        wait_captures(6, 200);

        // Backpressure: fill the FIFO, then one dropped capture, then a capture with a same-cycle pop.
        pdm.pdm_ready = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() < DEPTH; i++) tick();
        check("fifo_filled", exp_q.size(), DEPTH);
        check("valid_held", pdm.pdm_valid, 1);
        ovf0 = ovf_cnt;
        wait_captures(1, 60);
        check("overflow_pulse", ovf_cnt - ovf0, 1);
        check("overflow_model", ovf_cnt, exp_ovf);
        r0 = rises;
        for (int i = 0; i < 60 && rises == r0; i++) tick();
        repeat (h - 1) tick();
        c0 = captures;
        pdm.pdm_ready = 1'b1;
        tick();
        pdm.pdm_ready = 1'b0;
        check("pop_capture_seen", captures, c0 + 1);
        check("no_overflow_with_pop", ovf_cnt - ovf0, 1);

        // Stop mid-high-phase with three bits queued.
        pdm.pdm_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        pdm.pdm_ready = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() < 3; i++) tick();
        check("three_queued", exp_q.size(), 3);
        r0 = rises;
        for (int i = 0; i < 60 && rises == r0; i++) tick();
        tick();
        enable_i   = 1'b0;
        en_model   = 1'b0;
        pend_valid = 1'b0;
        k = 0;
        while (pdm_clk_o === 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check("stop_completes_high", k, h - 1);
        check("stop_to_idle", state_dbg, IDLE);
        highs = 0;
        repeat (12) begin
            tick();
            if (pdm_clk_o !== 1'b0) highs++;
        end
        check("clk_stays_low", highs, 0);
        pdm.pdm_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("busy_drain", busy_o, exp_q.size() != 0);
            if (exp_q.size() == 0) break;
        end
        check("busy_low_after_drain", busy_o, 0);

        // Falling-edge channel with random mic data.
        start_run(4, EDGE_FALLING, 1'b1);
        first_rise("first_rise_falling_sel");
        wait_captures(8, 400);
        stop_run();

        // clk_div below the synchroniser depth is clamped.
        start_run(1, EDGE_RISING, 1'b1);
        first_rise("first_rise_clamped");
        wait_captures(8, 400);
        check("period_clamped", period, 6);
        check("high_len_clamped", high_len, 3);
        stop_run();

        // Async reset mid-run with five bits queued and the bit clock high.
        start_run(4, EDGE_RISING, 1'b1);
        pdm.pdm_ready = 1'b0;
        for (int i = 0; i < 400 && exp_q.size() < 5; i++) tick();
        check("five_queued", exp_q.size(), 5);
        r0 = rises;
        for (int i = 0; i < 60 && rises == r0; i++) tick();
        tick();
        check("clk_high_before_reset", pdm_clk_o, 1);
        #1;
        reset_i = 1'b1;
        #1;
        check("arst_pdm_clk", pdm_clk_o, 0);
        check("arst_valid", pdm.pdm_valid, 0);
        check("arst_busy", busy_o, 0);
        exp_q.delete();
        en_model   = 1'b0;
        pend_valid = 1'b0;
        prev_clk   = 1'b0;
        enable_i   = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        pdm.pdm_ready = 1'b1;
        start_run(4, EDGE_RISING, 1'b1);
        first_rise("first_rise_after_reset");
        k = 0;
        while (pdm.pdm_valid !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check("warmup_repeated", falls, WB + 1);
        wait_captures(4, 100);
        stop_run();
        repeat (4) tick();
        check("overflow_total", ovf_cnt, exp_ovf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
